// File: rtl/hw_accel_downscale_2x2.sv
// 2x2 box-average downscaler: raster RGB stream in, half-resolution RGB stream out.
// Horizontal pairs are summed on the fly; even-line pair sums wait in a line buffer for the odd line.

module hw_accel_downscale_2x2_chan (
    input  logic [7:0] hold,
    input  logic [7:0] pix,
    input  logic [8:0] hsum_r,
    input  logic [8:0] lb_rd,
    output logic [8:0] hsum,
    output logic [7:0] avg
);
    logic [9:0] vsum;

    assign hsum = {1'b0, hold} + {1'b0, pix};
    // +2 before dropping two bits gives round-half-up /4; max 1022 fits in 10 bits
    assign vsum = {1'b0, hsum_r} + {1'b0, lb_rd} + 10'd2;
    assign avg  = vsum[9:2];
endmodule

module hw_accel_downscale_2x2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_valid,
    output logic                  frame_done,
    output logic                  line_done
);
    localparam int NUM_CH = 3;
    localparam int NCOL   = FRAME_WIDTH / 2;
    localparam int XW     = $clog2(FRAME_WIDTH);
    localparam int YW     = (FRAME_HEIGHT > 2) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int CW     = XW - 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NCOL - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [NUM_CH-1:0][7:0] hold_q, hold_d;
    logic [NUM_CH-1:0][8:0] hsum_q, hsum_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   odd_q, odd_d;
    logic                   last_row_q, last_row_d;
    // [0]: stage-1 pair sum valid, [1]: output pixel valid
    logic [1:0]             vld_pipe_q, vld_pipe_d;
    logic [NUM_CH-1:0][7:0] pix_out_q, pix_out_d;
    logic                   line_done_q, line_done_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_CH-1:0][7:0] pix_ch;
    logic [NUM_CH-1:0][8:0] hsum_c;
    logic [NUM_CH-1:0][7:0] avg_c;
    logic [NUM_CH-1:0][8:0] lb_mem [NCOL];
    logic [NUM_CH-1:0][8:0] lb_rdata_q;
    logic                   pair_beat, lb_re, lb_we, out_fire;
    logic                   unused_hi;

    assign pix_ch    = pixel_in[23:0];
    assign unused_hi = ^pixel_in[DATA_WIDTH-1:24];
    assign pair_beat = pixel_in_valid & x_q[0];
    assign lb_re     = pair_beat & y_q[0];
    assign lb_we     = vld_pipe_q[0] & ~odd_q;
    assign out_fire  = vld_pipe_q[0] & odd_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        hw_accel_downscale_2x2_chan u_chan (
            .hold   (hold_q[ch]),
            .pix    (pix_ch[ch]),
            .hsum_r (hsum_q[ch]),
            .lb_rd  (lb_rdata_q[ch]),
            .hsum   (hsum_c[ch]),
            .avg    (avg_c[ch])
        );
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        hold_d       = hold_q;
        hsum_d       = hsum_q;
        col_d        = col_q;
        odd_d        = odd_q;
        last_row_d   = last_row_q;
        pix_out_d    = pix_out_q;
        vld_pipe_d   = {out_fire, pair_beat};
        line_done_d  = out_fire && (col_q == C_LAST);
        frame_done_d = out_fire && (col_q == C_LAST) && last_row_q;

        if (pixel_in_valid) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            if (!x_q[0]) begin
                hold_d = pix_ch;
            end else begin
                hsum_d     = hsum_c;
                col_d      = x_q[XW-1:1];
                odd_d      = y_q[0];
                last_row_d = (y_q == Y_LAST);
            end
        end

        if (out_fire) pix_out_d = avg_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            hold_q       <= '0;
            hsum_q       <= '0;
            col_q        <= '0;
            odd_q        <= 1'b0;
            last_row_q   <= 1'b0;
            vld_pipe_q   <= '0;
            pix_out_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hold_q       <= hold_d;
            hsum_q       <= hsum_d;
            col_q        <= col_d;
            odd_q        <= odd_d;
            last_row_q   <= last_row_d;
            vld_pipe_q   <= vld_pipe_d;
            pix_out_q    <= pix_out_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read is launched with the odd-x beat so data lines up with hsum_q one cycle later
    always_ff @(posedge clk) begin
        if (lb_we) lb_mem[col_q] <= hsum_q;
        if (lb_re) lb_rdata_q <= lb_mem[x_q[XW-1:1]];
    end

    assign pixel_out       = {{(DATA_WIDTH-24){1'b0}}, pix_out_q};
    assign pixel_out_valid = vld_pipe_q[1];
    assign line_done       = line_done_q;
    assign frame_done      = frame_done_q;
endmodule
